// File: rtl/toggle_pattern_sequencer.sv
// Square-wave sequencer driving an external toggle flip-flop through one-cycle toggle pulses.
// Optional build macro TOGGLE_PATTERN_SEQUENCER_BURST_EN adds a self-terminating burst length.
//
// state  | meaning
// IDLE   | waiting for start handshake, flip-flop at 0
// LAUNCH | single cycle, pulses toggle to raise the flip-flop
// HIGH   | flip-flop at 1 for H cycles, toggle on the last one
// LOW    | flip-flop at 0 for L cycles, toggle on the last one unless stopping
module toggle_pattern_sequencer #(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned BURST_WIDTH   = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_i,
    input  logic                     start_valid_i,
    output logic                     start_ready_o,
    input  logic [COUNTER_WIDTH-1:0] high_cycles_i,
    input  logic [COUNTER_WIDTH-1:0] low_cycles_i,
    input  logic                     stop_i,
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
    input  logic [BURST_WIDTH-1:0]   burst_count_i,
`endif
    output logic                     toggle_o,
    output logic                     state_o,
    output logic                     busy_o,
    output logic                     done_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        HIGH   = 2'd2,
        LOW    = 2'd3
    } fsm_t;

    fsm_t                     fsm_q, fsm_d;
    logic [COUNTER_WIDTH-1:0] cnt_q, cnt_d;
    logic [COUNTER_WIDTH-1:0] h_len_q, h_len_d;
    logic [COUNTER_WIDTH-1:0] l_len_q, l_len_d;
    logic                     stop_q, stop_d;
    logic                     tff_q, tff_d;
    logic                     phase_end;
    logic                     end_hi;
    logic                     toggle;
    logic                     done;

`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
    logic [BURST_WIDTH-1:0]   burst_q, burst_d;

    // burst_q holds the number of high phases still to run, including the current one
    assign end_hi = stop_q || (burst_q == BURST_WIDTH'(1));
`else
    logic unused_burst_width;
    assign unused_burst_width = |BURST_WIDTH;
    assign end_hi = stop_q;
`endif

    assign phase_end = (cnt_q == '0);

    always_comb begin
        toggle = 1'b0;
        done   = 1'b0;
        case (fsm_q)
            LAUNCH:  toggle = 1'b1;
            HIGH: begin
                toggle = phase_end;
                done   = phase_end && end_hi;
            end
            LOW: begin
                toggle = phase_end && !stop_q;
                done   = phase_end && stop_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        h_len_d = h_len_q;
        l_len_d = l_len_q;
        stop_d  = stop_q;
        tff_d   = tff_q ^ toggle;
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
        burst_d = burst_q;
`endif
        if (fsm_q != IDLE && stop_i) begin
            stop_d = 1'b1;
        end
        case (fsm_q)
            IDLE: begin
                if (start_valid_i) begin
                    // lengths are stored minus one so that 0 and 1 both give one cycle
                    h_len_d = (high_cycles_i == '0) ? '0 : high_cycles_i - COUNTER_WIDTH'(1);
                    l_len_d = (low_cycles_i == '0) ? '0 : low_cycles_i - COUNTER_WIDTH'(1);
                    fsm_d   = LAUNCH;
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
                    burst_d = burst_count_i;
`endif
                end
            end
            LAUNCH: begin
                fsm_d = HIGH;
                cnt_d = h_len_q;
            end
            HIGH: begin
                if (!phase_end) begin
                    cnt_d = cnt_q - COUNTER_WIDTH'(1);
                end else if (end_hi) begin
                    fsm_d  = IDLE;
                    stop_d = 1'b0;
                end else begin
                    fsm_d = LOW;
                    cnt_d = l_len_q;
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
                    if (burst_q != '0) begin
                        burst_d = burst_q - BURST_WIDTH'(1);
                    end
`endif
                end
            end
            LOW: begin
                if (!phase_end) begin
                    cnt_d = cnt_q - COUNTER_WIDTH'(1);
                end else if (stop_q) begin
                    fsm_d  = IDLE;
                    stop_d = 1'b0;
                end else begin
                    fsm_d = HIGH;
                    cnt_d = h_len_q;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            fsm_q   <= IDLE;
            cnt_q   <= '0;
            h_len_q <= '0;
            l_len_q <= '0;
            stop_q  <= 1'b0;
            tff_q   <= 1'b0;
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
            burst_q <= '0;
`endif
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            h_len_q <= h_len_d;
            l_len_q <= l_len_d;
            stop_q  <= stop_d;
            tff_q   <= tff_d;
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
            burst_q <= burst_d;
`endif
        end
    end

    assign toggle_o      = toggle;
    assign done_o        = done;
    assign state_o       = tff_q;
    assign busy_o        = (fsm_q != IDLE);
    assign start_ready_o = (fsm_q == IDLE);

endmodule

// File: tb/tb_toggle_pattern_sequencer.sv
// Directed bench for toggle_pattern_sequencer; burst checks run when
// TOGGLE_PATTERN_SEQUENCER_BURST_EN is defined.
module tb_toggle_pattern_sequencer;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic [7:0] high_cycles;
    logic [7:0] low_cycles;
    logic [7:0] burst_count;
    logic       stop;
    logic       toggle;
    logic       state;
    logic       busy;
    logic       done;

    int n_asserts = 0;
    int n_fail    = 0;

    always #5 clock = ~clock;

    toggle_pattern_sequencer #(
        .COUNTER_WIDTH(8),
        .BURST_WIDTH  (8)
    ) dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_valid_i(start_valid),
        .start_ready_o(start_ready),
        .high_cycles_i(high_cycles),
        .low_cycles_i (low_cycles),
        .stop_i       (stop),
`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
        .burst_count_i(burst_count),
`endif
        .toggle_o     (toggle),
        .state_o      (state),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_asserts++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic e_tog, input logic e_st,
                           input logic e_busy, input logic e_done, input logic e_rdy);
        chk({tag, ".toggle"}, toggle, e_tog);
        chk({tag, ".state"}, state, e_st);
        chk({tag, ".busy"}, busy, e_busy);
        chk({tag, ".done"}, done, e_done);
        chk({tag, ".start_ready"}, start_ready, e_rdy);
    endtask

    // Accept edge, then the LAUNCH cycle: toggle=1 with the flip-flop still 0.
    task automatic accept(input logic [7:0] h, input logic [7:0] l, input logic [7:0] n);
        start_valid = 1'b1;
        high_cycles = h;
        low_cycles  = l;
        burst_count = n;
        step();
        start_valid = 1'b0;
        chk_out("launch", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        reset       = 1'b1;
        start_valid = 1'b0;
        high_cycles = '0;
        low_cycles  = '0;
        burst_count = '0;
        stop        = 1'b0;
        repeat (2) step();
        chk_out("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        chk_out("idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // H=3, L=2: after LAUNCH, period 5 with toggles at offsets 2 and 4
        accept(8'd3, 8'd2, 8'd0);
        for (int k = 1; k <= 50; k++) begin
            int p;
            step();
            p = (k - 1) % 5;
            chk_out("h3l2", (p == 2) || (p == 4), p < 3, 1'b1, 1'b0, 1'b0);
        end

        reset = 1'b1;
        repeat (2) step();
        chk_out("rst_mid", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        reset = 1'b0;
        step();
        chk_out("rst_rel", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // H=0, L=0 behaves as 1/1
        accept(8'd0, 8'd0, 8'd0);
        for (int k = 1; k <= 8; k++) begin
            step();
            chk_out("h0l0", 1'b1, k[0], 1'b1, 1'b0, 1'b0);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        chk_out("h0l0_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // H=4, L=4, stop in 2nd HIGH cycle; start_valid held meanwhile with other lengths
        accept(8'd4, 8'd4, 8'd0);
        step();
        chk_out("s44_k1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        start_valid = 1'b1;
        high_cycles = 8'd1;
        low_cycles  = 8'd1;
        step();
        chk_out("s44_k2", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step();
        stop        = 1'b0;
        start_valid = 1'b0;
        chk_out("s44_k3", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("s44_k4", 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        chk_out("s44_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // stop while idle must not be latched
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_out("idle_stop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

        // H=2, L=5, stop in 1st LOW cycle
        accept(8'd2, 8'd5, 8'd0);
        step();
        chk_out("s25_k1", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("s25_k2", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        chk_out("s25_k3", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk_out("s25_k4", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 5; k <= 6; k++) begin
            step();
            chk_out("s25_low", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        step();
        chk_out("s25_k7", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        chk_out("s25_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

`ifdef TOGGLE_PATTERN_SEQUENCER_BURST_EN
        // burst of 3, H=2, L=1: period 3, done on the 3rd falling toggle (k=8)
        accept(8'd2, 8'd1, 8'd3);
        for (int k = 1; k <= 8; k++) begin
            int p;
            step();
            p = (k - 1) % 3;
            chk_out("burst", p != 0, p < 2, 1'b1, k == 8, 1'b0);
        end
        step();
        chk_out("burst_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
